// File: rtl/natalius_wb_gpio_if.sv
// natalius_wb_gpio_if: Wishbone slave bus bundle for the natalius GPIO bank.
interface natalius_wb_gpio_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/natalius_wb_gpio.sv
// natalius_wb_gpio: Wishbone GPIO bank with per-pin direction, set/clear writes and edge IRQs.
// Define GPIO_DEBOUNCE_EN to insert a per-pin debounce filter after the input synchroniser.
module natalius_wb_gpio #(
    parameter int          WIDTH           = 16,
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    natalius_wb_gpio_if.slave wbs,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oeb,
    output logic              irq
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_nxt;
    logic hit, commit, wr, unused;
    logic [2:0] off;
    logic [31:0] wmask, wd, rdata, dat_q;
    logic [WIDTH-1:0] d, dout, oeb, irq_en, irq_pol, irq_stat, filt, prev, ev;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;

    assign hit   = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign off   = wbs.wbs_adr_i[4:2];
    assign wmask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}}, {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
    assign wd    = wbs.wbs_dat_i & wmask;
    assign d     = wd[WIDTH-1:0];
    assign wr    = commit & wbs.wbs_we_i;
    assign ev    = (irq_pol & ~filt & prev) | (~irq_pol & filt & ~prev);
    assign unused = ^{wbs.wbs_adr_i[1:0], wd, 16'(DEBOUNCE_CYCLES)};

    assign wbs.wbs_ack_o = (state == ACK);
    assign wbs.wbs_dat_o = dat_q;
    assign gpio_out      = dout;
    assign gpio_oeb      = oeb;

    always_comb begin
        commit    = (state == IDLE) && hit;
        state_nxt = commit ? ACK : IDLE;
    end

    always_comb begin
        rdata = '0;
        case (off)
            3'd0:    rdata = 32'(filt);
            3'd1:    rdata = 32'(dout);
            3'd2:    rdata = 32'(oeb);
            3'd3:    rdata = 32'(irq_en);
            3'd4:    rdata = 32'(irq_pol);
            3'd5:    rdata = 32'(irq_stat);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dat_q    <= '0;
            dout     <= '0;
            oeb      <= '1;
            irq_en   <= '0;
            irq_pol  <= '0;
            irq_stat <= '0;
            sync     <= '0;
            prev     <= '0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            dat_q    <= (commit && !wbs.wbs_we_i) ? rdata : '0;
            sync     <= {sync[SYNC_STAGES-2:0], gpio_in};
            prev     <= filt;
            irq      <= |(irq_stat & irq_en);
            // a same-cycle event wins over write-1-to-clear
            irq_stat <= (irq_stat & ~((wr && off == 3'd5) ? d : '0)) | ev;
            if (wr) begin
                case (off)
                    3'd1:    dout    <= (dout & ~wmask[WIDTH-1:0]) | d;
                    3'd2:    oeb     <= (oeb & ~wmask[WIDTH-1:0]) | d;
                    3'd3:    irq_en  <= (irq_en & ~wmask[WIDTH-1:0]) | d;
                    3'd4:    irq_pol <= (irq_pol & ~wmask[WIDTH-1:0]) | d;
                    3'd6:    dout    <= dout | d;
                    3'd7:    dout    <= dout & ~d;
                    default: ;
                endcase
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] cnt [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[SYNC_STAGES-1][i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i] <= sync[SYNC_STAGES-1][i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end
`else
    assign filt = sync[SYNC_STAGES-1];
`endif
endmodule

// File: tb/tb_natalius_wb_gpio.sv
// tb_natalius_wb_gpio: scoreboard bench for the natalius Wishbone GPIO bank.
module tb_natalius_wb_gpio;
    localparam int WIDTH = 16;
    localparam int SYNC  = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = SYNC + 16;
`else
    localparam int LAT = SYNC;
`endif
    localparam logic [31:0] B = 32'h3000_0000;

    typedef struct packed {
        logic        chk;
        logic [31:0] exp;
        logic [4:0]  off;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [WIDTH-1:0] gpio_in = '0;
    logic [WIDTH-1:0] gpio_out, gpio_oeb;
    logic irq;
    int total = 0;
    int bad = 0;
    item_t sb[$];
    item_t it;

    natalius_wb_gpio_if wb();

    natalius_wb_gpio #(
        .WIDTH(WIDTH), .BASE_ADDR(B), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wbs(wb),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // monitor: every ack consumes one scoreboard entry
    always @(negedge clk) begin
        if (wb.wbs_ack_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: ack=1 with no access outstanding");
            end else begin
                it = sb.pop_front();
                if (it.chk) check($sformatf("rdata@%02h", it.off), wb.wbs_dat_o, it.exp);
            end
        end
    end

    task automatic wb_acc(input logic we, input logic [4:0] off, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp);
        int n = 0;
        sb.push_back('{!we, exp, off});
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = B | 32'(off);
        wb.wbs_dat_i = dat;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb.wbs_ack_o && n < 8);
        check("ack_latency", 32'(n), 1);
        @(posedge clk);
        #1;
        check("ack_width", {31'b0, wb.wbs_ack_o}, 0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] off, input logic [31:0] exp);
        wb_acc(1'b0, off, 32'h0, 4'h0, exp);
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] dat, input logic [3:0] sel);
        wb_acc(1'b1, off, dat, sel, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, wb.wbs_ack_o}, 0);
        check("rst_oeb", 32'(gpio_oeb), 32'hFFFF);
        check("rst_out", 32'(gpio_out), 0);
        check("rst_irq", {31'b0, irq}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(5'h00, 0); rd(5'h04, 0); rd(5'h08, 32'hFFFF); rd(5'h0C, 0);
        rd(5'h10, 0); rd(5'h14, 0); rd(5'h18, 0); rd(5'h1C, 0);

        wr(5'h04, 32'h0000_00A5, 4'b0001);
        wr(5'h18, 32'h0000_0F00, 4'hF);
        wr(5'h1C, 32'h0000_0005, 4'hF);
        check("dout_setclr", 32'(gpio_out), 32'h0FA0);
        wr(5'h04, 32'h1234_FFFF, 4'b0010);
        check("dout_sel", 32'(gpio_out), 32'hFFA0);
        rd(5'h04, 32'hFFA0); rd(5'h18, 0); rd(5'h1C, 0);
        wr(5'h08, 32'hFFFF_0000, 4'hF);
        check("oeb_width", 32'(gpio_oeb), 0);
        wr(5'h08, 32'hFFFF_FFFF, 4'b1100);
        rd(5'h08, 0);

        // rising edge on pin 0
        wr(5'h0C, 32'h1, 4'hF);
        wr(5'h10, 32'h0, 4'hF);
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("irq_edge%0d", k), {31'b0, irq}, {31'b0, k >= LAT + 2});
        end
        rd(5'h00, 32'h1); rd(5'h14, 32'h1);
        wr(5'h14, 32'h1, 4'hF);
        check("irq_after_clr", {31'b0, irq}, 0);
        rd(5'h14, 0);

        // falling edge ignored while POL selects rising
        gpio_in[0] = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        rd(5'h14, 0);
        check("irq_no_fall", {31'b0, irq}, 0);
        gpio_in[0] = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("irq_rise2", {31'b0, irq}, 1);
        wr(5'h10, 32'h1, 4'hF);
        rd(5'h14, 32'h1);

        // falling event lands on the same edge as the clear
        gpio_in[0] = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        wr(5'h14, 32'h1, 4'hF);
        check("irq_coincide", {31'b0, irq}, 1);
        repeat (2) @(posedge clk);
        #1;
        check("irq_hold", {31'b0, irq}, 1);
        rd(5'h14, 32'h1);
        wr(5'h14, 32'h1, 4'hF);
        wr(5'h10, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        rd(5'h14, 0);

        // non-hit access
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_adr_i = 32'h3000_0100;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) n++;
        end
        check("nonhit_acks", 32'(n), 0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        @(posedge clk);
        #1;

        // reset during ack, no scoreboard entry since it must never be seen
        wr(5'h08, 32'h0, 4'hF);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_adr_i = B | 32'h4;
        @(posedge clk);
        #1;
        check("ack_pre_rst", {31'b0, wb.wbs_ack_o}, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", {31'b0, wb.wbs_ack_o}, 0);
        check("rst_mid_dat", wb.wbs_dat_o, 0);
        check("rst_mid_out", 32'(gpio_out), 0);
        check("rst_mid_oeb", 32'(gpio_oeb), 32'hFFFF);
        check("rst_mid_irq", {31'b0, irq}, 0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(5'h04, 0);

        gpio_in = 16'h5A3C;
        repeat (LAT + 2) @(posedge clk);
        #1;
        rd(5'h00, 32'h5A3C);
        gpio_in = '0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        rd(5'h00, 0);

`ifdef GPIO_DEBOUNCE_EN
        wr(5'h14, 32'hFFFF, 4'hF);
        gpio_in[3] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        gpio_in[3] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rd(5'h00, 0);
        rd(5'h14, 0);
        gpio_in[3] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rd(5'h00, 0);
        repeat (8) @(posedge clk);
        #1;
        rd(5'h00, 32'h8);
`endif

        check("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
